// File: rtl/alu_muldiv_seq.sv
// Iterative signed/unsigned multiply-divide unit writing HI/LO, one bit per cycle.
// Optional MULDIV_EARLY_EXIT_EN: zero operands skip the iteration phase.
module alu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       o_dbg_state
);

  // Handshake: a request is accepted on a rising edge where start==1, op is
  // valid and busy==0; done pulses for one cycle when hi/lo become valid.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_acc, r_mq, r_b, r_a;
  logic               r_is_div, r_sa, r_sb, r_bzero;

  logic               w_op_valid, w_is_div, w_signed, w_accept, w_early;
  logic               w_sa, w_sb;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [WIDTH:0]     w_add, w_rem_sh;
  logic [WIDTH-1:0]   w_rem_sub, w_div_acc, w_div_mq, w_mul_acc, w_mul_mq;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0]   w_q_fix, w_r_fix;

  assign w_op_valid = (op == 4'd6) || (op == 4'd7) || (op == 4'd8) || (op == 4'd9);
  assign w_is_div   = (op == 4'd7) || (op == 4'd9);
  assign w_signed   = (op == 4'd6) || (op == 4'd7);
  assign w_accept   = (r_state == S_IDLE) && start && w_op_valid;
  assign w_sa       = w_signed & a[WIDTH-1];
  assign w_sb       = w_signed & b[WIDTH-1];
  // The most-negative value negates to itself, which is its correct unsigned magnitude.
  assign w_abs_a    = w_sa ? -a : a;
  assign w_abs_b    = w_sb ? -b : b;

`ifdef MULDIV_EARLY_EXIT_EN
  assign w_early = (a == '0) || (b == '0);
`else
  assign w_early = 1'b0;
`endif

  // Shift-add multiply step: {acc,mq} holds the partial product, mq's LSB is the next multiplier bit.
  assign w_add     = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_b} : '0);
  assign w_mul_acc = w_add[WIDTH:1];
  assign w_mul_mq  = {w_add[0], r_mq[WIDTH-1:1]};

  // Restoring divide step: remainder in acc, dividend bits shift out of mq while quotient bits shift in.
  assign w_rem_sh  = {r_acc, r_mq[WIDTH-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_b;
  assign w_div_acc = w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
  assign w_div_mq  = {r_mq[WIDTH-2:0], w_ge};

  assign w_prod     = {r_acc, r_mq};
  assign w_prod_fix = (r_sa ^ r_sb) ? -w_prod : w_prod;
  assign w_q_fix    = (r_sa ^ r_sb) ? -r_mq : r_mq;
  assign w_r_fix    = r_sa ? -r_acc : r_acc;

  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_early ? S_FIX : S_RUN;
      S_RUN:   if (r_cnt == '0) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mq        <= '0;
      r_b         <= '0;
      r_a         <= '0;
      r_is_div    <= 1'b0;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_bzero     <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            div_by_zero <= 1'b0;
            r_is_div    <= w_is_div;
            r_sa        <= w_sa;
            r_sb        <= w_sb;
            r_a         <= a;
            r_b         <= w_abs_b;
            r_bzero     <= (b == '0);
            r_acc       <= '0;
            r_mq        <= w_early ? '0 : w_abs_a;
            r_cnt       <= CNT_W'(WIDTH - 1);
          end
        end
        S_RUN: begin
          r_acc <= r_is_div ? w_div_acc : w_mul_acc;
          r_mq  <= r_is_div ? w_div_mq : w_mul_mq;
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        end
        S_FIX: begin
          done <= 1'b1;
          if (r_is_div && r_bzero) begin
            hi          <= r_a;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end else if (r_is_div) begin
            hi <= w_r_fix;
            lo <= w_q_fix;
          end else begin
            hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            lo <= w_prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: directed vector table, multi-cycle corner sequences,
// and randomized operations scored against an arithmetic reference model.
module tb_alu_muldiv_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic         dz;
  } vec_t;
  vec_t vecs[$];

  alu_muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference results straight from signed/unsigned integer arithmetic.
  function automatic void model(input logic [3:0] mop, input logic [W-1:0] ma, mb,
                                output logic [W-1:0] mhi, mlo, output logic mdz);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    mhi = '0; mlo = '0; mdz = 1'b0;
    case (mop)
      4'd6: begin p = sa * sb; mhi = p[63:32]; mlo = p[31:0]; end
      4'd8: begin p = {32'b0, ma} * {32'b0, mb}; mhi = p[63:32]; mlo = p[31:0]; end
      4'd7: begin
        if (mb == 0) begin mhi = ma; mlo = '1; mdz = 1'b1; end
        else begin sq = sa / sb; sr = sa % sb; mlo = sq[31:0]; mhi = sr[31:0]; end
      end
      4'd9: begin
        if (mb == 0) begin mhi = ma; mlo = '1; mdz = 1'b1; end
        else begin mlo = ma / mb; mhi = ma % mb; end
      end
      default: ;
    endcase
  endfunction

  function automatic int exp_lat(input logic [W-1:0] ea, eb);
`ifdef MULDIV_EARLY_EXIT_EN
    return (ea == 0 || eb == 0) ? 1 : W + 1;
`else
    return W + 1;
`endif
  endfunction

  // Issues one op and returns cycles from the accepting edge to the done edge.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, y,
                        output int lat, output logic busy_ok);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 4'($urandom_range(0, 15));
    lat = 0;
    busy_ok = busy;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (!done && !busy) busy_ok = 1'b0;
    end
    if (done && busy) busy_ok = 1'b0;
  endtask

  task automatic check_vec(input string name, input logic [3:0] o, input logic [W-1:0] x, y,
                           input logic [W-1:0] ehi, elo, input logic edz);
    int lat;
    logic bok;
    run_op(o, x, y, lat, bok);
    chk({name, ".latency"}, 64'(lat), 64'(exp_lat(x, y)));
    chk({name, ".hi"}, 64'(hi), 64'(ehi));
    chk({name, ".lo"}, 64'(lo), 64'(elo));
    chk({name, ".dz"}, 64'(div_by_zero), 64'(edz));
    chk({name, ".busy"}, 64'(bok), 64'(1));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return '1;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, extra;
    logic bok;
    logic [W-1:0] mh, ml, pre_hi, pre_lo;
    logic md;

    vecs.push_back('{"mult_neg3x7",  4'd6, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});
    vecs.push_back('{"multu_max",    4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
    vecs.push_back('{"multu_2x3",    4'd8, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0});
    vecs.push_back('{"div_neg7_2",   4'd7, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{"divu_7_2",     4'd9, 32'd7,         32'd2,         32'd1,         32'd3,         1'b0});
    vecs.push_back('{"div_5_0",      4'd7, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{"mult_clr_dz",  4'd6, 32'd5,         32'd6,         32'd0,         32'd30,        1'b0});
    vecs.push_back('{"div_minneg",   4'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0});
    vecs.push_back('{"mult_minneg",  4'd6, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0});
    vecs.push_back('{"div_neg7_0",   4'd7, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{"divu_9_0",     4'd9, 32'd9,         32'd0,         32'd9,         32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{"div_7_neg2",   4'd7, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{"mult_zero",    4'd6, 32'd0,         32'd12345,     32'd0,         32'd0,         1'b0});
    vecs.push_back('{"div_zero_num", 4'd7, 32'd0,         32'd5,         32'd0,         32'd0,         1'b0});

    // Clock/reset
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset.busy", 64'(busy), 64'(0));
    chk("reset.done", 64'(done), 64'(0));
    chk("reset.dz",   64'(div_by_zero), 64'(0));
    chk("reset.hi",   64'(hi), 64'(0));
    chk("reset.lo",   64'(lo), 64'(0));

    // Directed table; consecutive entries start in the previous done cycle.
    foreach (vecs[i])
      check_vec(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz);

    // Back-to-back: the next request is raised while done is still high.
    run_op(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bok);
    chk("b2b.first_done", 64'(done), 64'(1));
    check_vec("b2b.second", 4'd8, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
    @(posedge clk); #1;
    chk("done.one_cycle", 64'(done), 64'(0));

    // Start while busy with different operands is dropped.
    @(negedge clk);
    start = 1'b1; op = 4'd6; a = 32'd1234; b = 32'd5678;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      if (lat == 5) begin
        @(negedge clk);
        start = 1'b1; op = 4'd9; a = 32'd100; b = 32'd0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    model(4'd6, 32'd1234, 32'd5678, mh, ml, md);
    chk("busy_start.latency", 64'(lat), 64'(W + 1));
    chk("busy_start.hi", 64'(hi), 64'(mh));
    chk("busy_start.lo", 64'(lo), 64'(ml));
    chk("busy_start.dz", 64'(div_by_zero), 64'(md));
    extra = 0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) extra++; end
    chk("busy_start.no_queue", 64'(extra), 64'(0));

    // Reset ten cycles into an op aborts it.
    @(negedge clk);
    start = 1'b1; op = 4'd6; a = 32'hFFFF_FFFD; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("abort.busy", 64'(busy), 64'(0));
    chk("abort.hi",   64'(hi), 64'(0));
    chk("abort.lo",   64'(lo), 64'(0));
    @(negedge clk); reset = 1'b0;
    extra = 0;
    repeat (40) begin @(posedge clk); #1; if (done) extra++; end
    chk("abort.no_done", 64'(extra), 64'(0));

    // Invalid op code is ignored.
    @(negedge clk);
    start = 1'b1; op = 4'd3; a = 32'd5; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("invalid.busy", 64'(busy), 64'(0));
    extra = 0;
    repeat (5) begin @(posedge clk); #1; if (done || busy) extra++; end
    chk("invalid.idle", 64'(extra), 64'(0));
    chk("invalid.hi", 64'(hi), 64'(0));
    chk("invalid.lo", 64'(lo), 64'(0));

    // Randomized ops scored against the model through the expected queue.
    for (int i = 0; i < 150; i++) begin
      logic [3:0]   ro;
      logic [W-1:0] ra, rb, ehi, elo;
      ro = 4'(6 + $urandom_range(0, 3));
      ra = pick();
      rb = pick();
      model(ro, ra, rb, mh, ml, md);
      exp_q.push_back(mh);
      exp_q.push_back(ml);
      ehi = exp_q.pop_front();
      elo = exp_q.pop_front();
      pre_hi = hi; pre_lo = lo;
      check_vec($sformatf("rand%0d_op%0d_%h_%h", i, ro, ra, rb), ro, ra, rb, ehi, elo, md);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
